imem_loader: RTL
================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter: BASE_ADDR, 16'h0000, byte address where the first loaded word is written.
REQ-002 Parameter: MAX_WORDS, 16384, largest accepted word count.
REQ-003 Port: clk  in  1  single clock; all state changes on its rising edge.
REQ-004 Port: rst  in  1  asynchronous, active-low reset.
REQ-005 Port: in_valid  in  1  byte-stream source has a byte on in_data.
REQ-006 Port: in_data  in  8  stream byte.
REQ-007 Port: in_ready  out  1  loader accepts a byte; a transfer occurs when in_valid && in_ready at a clk edge.
REQ-008 Port: w_mask  out  8  byte write mask to instruction memory.
REQ-009 Port: address  out  16  instruction memory byte address.
REQ-010 Port: write_data  out  64  instruction memory write data.
REQ-011 Port: core_hold  out  1  keeps the core in reset while high.
REQ-012 Port: done  out  1  image loaded and checksum verified.
REQ-013 Port: error  out  1  load aborted.

Function
REQ-014 Stream format: sync byte 8'hA5; word count N as 2 bytes, little-endian; N words of 4 bytes each, little-endian; 1 checksum byte.
REQ-015 The FSM SHALL have states IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR.
REQ-016 IDLE: a transfer of 8'hA5 moves the FSM to LEN0; any other byte is dropped and the FSM stays in IDLE.
REQ-017 LEN0: the transfer captures N[7:0], then the FSM goes to LEN1.
REQ-018 LEN1: the transfer captures N[15:8].
REQ-019 LEN1 exit: if N==0 or N>MAX_WORDS the FSM goes to ERR; otherwise it goes to DATA with word index and byte index cleared.
REQ-020 DATA: each transfer shifts its byte into the word assembler at position byte index (0 = bits 7:0).
REQ-021 DATA: each transfer XORs its byte into the running checksum; the checksum is cleared on entry to LEN0.
REQ-022 DATA: when the 4th byte of a word is accepted, in the NEXT cycle only: w_mask=8'h0F, address=BASE_ADDR+4*word index (mod 2^16), write_data={32'h0, assembled word}.
REQ-023 DATA: after the last word (word index N-1) is accepted, the FSM goes to CSUM.
REQ-024 When no write is pending, w_mask SHALL be 8'h00; address and write_data SHALL then hold their last values.
REQ-025 CSUM: the transfer compares its byte with the running checksum; match goes to DONE, mismatch goes to ERR.
REQ-026 in_ready SHALL be 1 in IDLE, LEN0, LEN1, DATA and CSUM, and 0 in DONE and ERR.
REQ-027 No backpressure: consecutive bytes are accepted every cycle, and a write cycle overlaps acceptance of the next word's first byte.
REQ-028 in_valid low stalls the FSM in place with no timeout.
REQ-029 Outputs per state: core_hold=1 in every state except DONE; done=1 only in DONE; error=1 only in ERR.
REQ-030 DONE and ERR SHALL be terminal until reset.
REQ-031 The final data word's write cycle SHALL complete even if the FSM has already left DATA.
REQ-032 Address wrap past 16'hFFFC SHALL wrap modulo 2^16 with no error.

Reset
REQ-033 Reset takes effect immediately when rst goes low, with no clock required.
REQ-034 Reset values: state=IDLE, w_mask=8'h00, address=16'h0000, write_data=64'h0, core_hold=1, done=0, error=0, in_ready=0 while rst is low.
REQ-035 Reset also clears N, the indices, the assembler and the checksum.
REQ-036 Reset asserted mid-load aborts the load with no further writes; after release a load restarts from IDLE.

Verification
REQ-037 Normal load: stream A5 02 00 13 00 00 00 93 00 10 00 XOR-sum -> writes {addr 0000, data 0000000000000013, mask 0F} then {addr 0004, data 0000000000100093, mask 0F}; then done=1, core_hold=0, in_ready=0.
REQ-038 Bad checksum: same stream with its checksum byte inverted -> both writes occur; error=1, done=0, core_hold=1.
REQ-039 Bad length: A5 00 00 -> ERR with no write; separately A5 01 40 (N=16385) -> ERR with no write.
REQ-040 Sync filtering and stalls: 00 FF A5 01 00 then a word with in_valid toggling every cycle -> leading junk ignored; exactly one write; address = BASE_ADDR.
REQ-041 Mid-load reset: pull rst low after 2 data bytes of word 1 -> outputs at reset values immediately; a subsequent full load succeeds from word 0.
REQ-042 Wrap: BASE_ADDR=16'hFFFC with N=2 -> writes go to addresses FFFC then 0000, and done=1.

Source files
------------

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module  : imem_loader
// Brief   : Byte-stream boot loader; writes a checksummed image into IMEM.
// Revision: 1.0
// ============================================================================
module imem_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter int          MAX_WORDS = 16384
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [7:0]  w_mask,
  output logic [15:0] address,
  output logic [63:0] write_data,
  output logic        core_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LEN0 = 3'd1,
    LEN1 = 3'd2,
    DATA = 3'd3,
    CSUM = 3'd4,
    DONE = 3'd5,
    ERR  = 3'd6
  } state_t;

  localparam logic [7:0]  c_sync      = 8'hA5;
  localparam logic [16:0] c_max_words = 17'(MAX_WORDS);

  state_t      r_state;
  logic [15:0] r_len;
  logic [15:0] r_word_idx;
  logic [1:0]  r_byte_idx;
  logic [23:0] r_word;
  logic [7:0]  r_csum;

  logic        w_xfer;
  logic [15:0] w_len_full;
  logic        w_len_bad;
  logic [15:0] w_addr;

  assign w_xfer     = in_valid & in_ready;
  assign w_len_full = {in_data, r_len[7:0]};
  assign w_len_bad  = (w_len_full == 16'd0) || ({1'b0, w_len_full} > c_max_words);
  // Byte address of the current word; wraps naturally at 16 bits.
  assign w_addr     = BASE_ADDR + (r_word_idx << 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_len      <= 16'h0000;
      r_word_idx <= 16'h0000;
      r_byte_idx <= 2'd0;
      r_word     <= 24'h000000;
      r_csum     <= 8'h00;
      in_ready   <= 1'b0;
      w_mask     <= 8'h00;
      address    <= 16'h0000;
      write_data <= 64'h0;
      core_hold  <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      // A write strobe lasts exactly one cycle; address/data hold afterwards.
      w_mask <= 8'h00;
      case (r_state)
        IDLE: begin
          in_ready <= 1'b1;
          if (w_xfer && (in_data == c_sync)) begin
            r_state <= LEN0;
            r_csum  <= 8'h00;
          end
        end
        LEN0: begin
          if (w_xfer) begin
            r_len[7:0] <= in_data;
            r_state    <= LEN1;
          end
        end
        LEN1: begin
          if (w_xfer) begin
            r_len[15:8] <= in_data;
            r_word_idx  <= 16'h0000;
            r_byte_idx  <= 2'd0;
            if (w_len_bad) begin
              r_state  <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              r_state <= DATA;
            end
          end
        end
        DATA: begin
          if (w_xfer) begin
            r_csum     <= r_csum ^ in_data;
            r_byte_idx <= r_byte_idx + 2'd1;
            case (r_byte_idx)
              2'd0: r_word[7:0]   <= in_data;
              2'd1: r_word[15:8]  <= in_data;
              2'd2: r_word[23:16] <= in_data;
              default: begin
                w_mask     <= 8'h0F;
                address    <= w_addr;
                write_data <= {32'h0, in_data, r_word};
                r_word_idx <= r_word_idx + 16'd1;
                if (r_word_idx == (r_len - 16'd1)) begin
                  r_state <= CSUM;
                end
              end
            endcase
          end
        end
        CSUM: begin
          if (w_xfer) begin
            in_ready <= 1'b0;
            if (in_data == r_csum) begin
              r_state   <= DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              r_state <= ERR;
              error   <= 1'b1;
            end
          end
        end
        DONE: begin
          in_ready <= 1'b0;
        end
        ERR: begin
          in_ready <= 1'b0;
        end
        default: begin
          r_state  <= ERR;
          in_ready <= 1'b0;
          error    <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
